// File: rtl/neuron_sweep_scheduler.sv
// Time-multiplexes one LIF update datapath over N_NEURONS and queues spike events in a FIFO.
// Build option: define SWEEP_REFRACTORY_EN to skip, for one sweep, neurons that just spiked.
module neuron_sweep_scheduler #(
    parameter int unsigned N_NEURONS  = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             tick,
    input  logic             clr,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    input  logic             upd_ready,
    input  logic             upd_spike,
    output logic             ev_valid,
    output logic [IDX_W-1:0] ev_idx,
    input  logic             ev_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             tick_missed
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NEURONS - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic tick_accept;
    logic skip;
    logic xfer;
    logic advance;
    logic last;

    assign tick_accept = tick && enable && (state_q == StIdle);
    assign xfer        = upd_valid && upd_ready;
    assign advance     = xfer || skip;
    assign last        = (idx_q == LastIdx);

`ifdef SWEEP_REFRACTORY_EN
    // mask_q gates the running sweep; spiked_q collects this sweep's spikes for the next one.
    logic [N_NEURONS-1:0] mask_q, mask_d;
    logic [N_NEURONS-1:0] spiked_q, spiked_d;

    assign skip = (state_q == StIssue) && mask_q[idx_q];

    always_comb begin
        mask_d   = mask_q;
        spiked_d = spiked_q;
        if (tick_accept) begin
            spiked_d = '0;
        end
        if (xfer && upd_spike) begin
            spiked_d[idx_q] = 1'b1;
        end
        if (state_q == StDone) begin
            mask_d = spiked_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            spiked_q <= '0;
        end else begin
            mask_q   <= mask_d;
            spiked_q <= spiked_d;
        end
    end
`else
    assign skip = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (tick_accept) begin
                    state_d = StIssue;
                    idx_d   = '0;
                end
            end
            StIssue: begin
                if (advance) begin
                    if (last) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        upd_valid = (state_q == StIssue) && !skip;
        upd_idx   = idx_q;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
    end

    // Spike event FIFO
    logic [IDX_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;

    logic push_req;
    logic pop;
    logic full;
    logic drop;
    logic do_push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign push_req = xfer && upd_spike;
    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid && ev_ready;
    assign full     = (count_q == FullCnt);
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign drop     = push_req && full && !pop;
    assign do_push  = push_req && !drop;
    assign ev_idx   = ev_valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= upd_idx;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Sticky flags; a set in the same cycle as clr takes priority.
    logic overflow_q;
    logic tick_missed_q;
    logic miss_set;

    assign miss_set = tick && (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q    <= 1'b0;
            tick_missed_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr) begin
                overflow_q <= 1'b0;
            end
            if (miss_set) begin
                tick_missed_q <= 1'b1;
            end else if (clr) begin
                tick_missed_q <= 1'b0;
            end
        end
    end

    assign overflow    = overflow_q;
    assign tick_missed = tick_missed_q;

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// Self-checking bench for neuron_sweep_scheduler: vector tables per cycle plus an event scoreboard.
module tb_neuron_sweep_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk       = 1'b0;
    logic reset_n   = 1'b1;
    logic enable    = 1'b0;
    logic tick      = 1'b0;
    logic clr       = 1'b0;
    logic upd_ready = 1'b0;
    logic upd_spike = 1'b0;
    logic ev_ready  = 1'b0;
    logic upd_valid, ev_valid, busy, done, overflow, tick_missed;
    logic [IW-1:0] upd_idx, ev_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_sweep_scheduler #(
        .N_NEURONS (N),
        .IDX_W     (IW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .tick       (tick),
        .clr        (clr),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_ready  (upd_ready),
        .upd_spike  (upd_spike),
        .ev_valid   (ev_valid),
        .ev_idx     (ev_idx),
        .ev_ready   (ev_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .tick_missed(tick_missed)
    );

    typedef struct {
        logic          tick, en, rdy, spike, evr, clr;
        logic          exp_valid;
        logic [IW-1:0] exp_idx;
        logic          exp_busy, exp_done;
    } vec_t;

    vec_t          vecs[$];
    logic [IW-1:0] ev_q[$];
    logic          ovf_m  = 1'b0;
    logic          miss_m = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void add(input int t, en, rdy, sp, evr, cl, xv, xi, xb, xd);
        vec_t v;
        v.tick      = 1'(t);
        v.en        = 1'(en);
        v.rdy       = 1'(rdy);
        v.spike     = 1'(sp);
        v.evr       = 1'(evr);
        v.clr       = 1'(cl);
        v.exp_valid = 1'(xv);
        v.exp_idx   = IW'(xi);
        v.exp_busy  = 1'(xb);
        v.exp_done  = 1'(xd);
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input int evr, cl);
        add(0, 1, 1, 0, evr, cl, 0, 0, 0, 0);
    endfunction

    // Tick in idle, N issue cycles with the given spike mask, then the done cycle.
    function automatic void add_sweep(input int sp_mask, input int evr);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < int'(N); k++) begin
            add(0, 1, 1, (sp_mask >> k) & 1, evr, 0, 1, k, 1, 0);
        end
        add(0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
    endfunction

    task automatic run_vectors(input string tag);
        foreach (vecs[i]) begin
            vec_t v;
            logic popm;
            logic dropm;
            v = vecs[i];
            @(negedge clk);
            tick      = v.tick;
            enable    = v.en;
            upd_ready = v.rdy;
            upd_spike = v.spike;
            ev_ready  = v.evr;
            clr       = v.clr;
            #1;
            check($sformatf("%s[%0d] upd_valid", tag, i), int'(upd_valid), int'(v.exp_valid));
            check($sformatf("%s[%0d] upd_idx", tag, i), int'(upd_idx), int'(v.exp_idx));
            check($sformatf("%s[%0d] busy", tag, i), int'(busy), int'(v.exp_busy));
            check($sformatf("%s[%0d] done", tag, i), int'(done), int'(v.exp_done));
            check($sformatf("%s[%0d] ev_valid", tag, i), int'(ev_valid), int'(ev_q.size() != 0));
            if (ev_q.size() != 0) begin
                check($sformatf("%s[%0d] ev_idx", tag, i), int'(ev_idx), int'(ev_q[0]));
            end
            check($sformatf("%s[%0d] overflow", tag, i), int'(overflow), int'(ovf_m));
            check($sformatf("%s[%0d] tick_missed", tag, i), int'(tick_missed), int'(miss_m));
            // Model the effect of the coming clock edge.
            popm  = v.evr && (ev_q.size() != 0);
            dropm = 1'b0;
            if (popm) begin
                void'(ev_q.pop_front());
            end
            if (v.exp_valid && v.rdy && v.spike) begin
                if (ev_q.size() < int'(DEPTH)) ev_q.push_back(v.exp_idx);
                else dropm = 1'b1;
            end
            if (dropm) ovf_m = 1'b1;
            else if (v.clr) ovf_m = 1'b0;
            if (v.tick && v.exp_busy) miss_m = 1'b1;
            else if (v.clr) miss_m = 1'b0;
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        {tick, enable, upd_ready, upd_spike, ev_ready, clr} = '0;
        @(negedge clk);
        reset_n = 1'b1;
        ev_q.delete();
        ovf_m  = 1'b0;
        miss_m = 1'b0;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst upd_valid", int'(upd_valid), 0);
        check("rst upd_idx", int'(upd_idx), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst ev_valid", int'(ev_valid), 0);
        check("rst ev_idx", int'(ev_idx), 0);
        check("rst overflow", int'(overflow), 0);
        check("rst tick_missed", int'(tick_missed), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic sweep, spikes on 0 and 2, events drained in order.
        add_sweep(4'b0101, 0);
        add_idle(0, 0);
        repeat (4) add_idle(1, 0);
        run_vectors("sweep");

        // Stall on index 1, enable dropped mid-sweep, repeated tick, clr, tick with enable low.
        do_reset();
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_vectors("stall");

        // A missed tick coinciding with clr leaves the flag set.
        do_reset();
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 1, 1, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 3, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        add_idle(0, 1);
        add_idle(0, 0);
        run_vectors("clrwin");

`ifndef SWEEP_REFRACTORY_EN
        // Two full-spike sweeps into a depth-4 FIFO: first four kept, overflow sticky until clr.
        do_reset();
        add_sweep(4'b1111, 0);
        add_sweep(4'b1111, 0);
        add_idle(0, 0);
        add_idle(0, 1);
        add_idle(0, 0);
        repeat (6) add_idle(1, 0);
        run_vectors("ovf");

        // Push and pop on a full FIFO in the same cycle never drop.
        do_reset();
        add_sweep(4'b1111, 0);
        add_sweep(4'b1111, 1);
        add_idle(0, 0);
        repeat (6) add_idle(1, 0);
        run_vectors("fullpp");

        // Without the refractory option a spiking neuron is still issued next sweep.
        do_reset();
        add_sweep(4'b0010, 0);
        add_sweep(4'b0000, 0);
        repeat (3) add_idle(1, 0);
        run_vectors("norefr");
`else
        // Neuron 1 spikes in sweep 1, is skipped in sweep 2, issued again in sweep 3.
        do_reset();
        add_sweep(4'b0010, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 2, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 3, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        add_sweep(4'b0000, 0);
        repeat (3) add_idle(1, 0);
        run_vectors("refr");
`endif

        // Reset mid-sweep aborts: no done pulse, queued events gone.
        do_reset();
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0, 1, 1, 1, 0);
        run_vectors("abort");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort upd_valid", int'(upd_valid), 0);
        check("abort ev_valid", int'(ev_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        {tick, upd_spike} = '0;
        ev_q.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort[%0d] done", c), int'(done), 0);
            check($sformatf("abort[%0d] ev_valid", c), int'(ev_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
